// File: rtl/mem_read_buffer_pkg.sv
// Shared defaults for the memory buffer blocks (read and write side).
package mem_read_buffer_pkg;

  localparam int DATAWIDTH_DEFAULT       = 32;
  localparam int ADDRESSWIDTH_DEFAULT    = 30;
  localparam int BYTEENABLEWIDTH_DEFAULT = 4;
  localparam int FIFODEPTH_DEFAULT       = 32;
  localparam int FIFODEPTH_LOG2_DEFAULT  = 5;

endpackage : mem_read_buffer_pkg

// File: rtl/mem_read_fifo.sv
// Synchronous show-ahead FIFO with asynchronous clear.
// q always presents the oldest stored word (zero while empty).
// Pops on empty and pushes on full are dropped.
module mem_read_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int USE_MEMORY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   usedw
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   usedw_q;
  logic                  wr_en;
  logic                  rd_en;
  logic [WIDTH-1:0]      head;

  assign empty = (usedw_q == '0);
  assign full  = (usedw_q == CNT_MAX);
  assign usedw = usedw_q;
  assign wr_en = wrreq & ~full;
  assign rd_en = rdreq & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   usedw_q <= usedw_q + CNT_ONE;
        2'b01:   usedw_q <= usedw_q - CNT_ONE;
        default: usedw_q <= usedw_q;
      endcase
    end
  end

  if (USE_MEMORY != 0) begin : g_ram
    logic [WIDTH-1:0] mem [DEPTH];

    // Word storage, RAM style.
    // NOTE: the storage array has no reset so it can map onto a memory primitive; the empty mask on q hides stale contents.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= data;
    end

    assign head = mem[rd_ptr_q];
  end else begin : g_reg
    logic [WIDTH-1:0] mem [DEPTH];

    // Word storage in flops, cleared with the rest of the FIFO.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
        mem[wr_ptr_q] <= data;
      end
    end

    assign head = mem[rd_ptr_q];
  end

  assign q = empty ? '0 : head;

endmodule : mem_read_fifo

// File: rtl/mem_read_buffer.sv
// Avalon-MM pipelined read master that streams a word-aligned region into
// a show-ahead FIFO. Reads are throttled so that words already buffered
// plus reads still in flight never exceed the FIFO depth.
module mem_read_buffer
  import mem_read_buffer_pkg::*;
#(
  parameter int DATAWIDTH       = DATAWIDTH_DEFAULT,
  parameter int BYTEENABLEWIDTH = BYTEENABLEWIDTH_DEFAULT,
  parameter int ADDRESSWIDTH    = ADDRESSWIDTH_DEFAULT,
  parameter int FIFODEPTH       = FIFODEPTH_DEFAULT,
  parameter int FIFODEPTH_LOG2  = FIFODEPTH_LOG2_DEFAULT,
  parameter int FIFOUSEMEMORY   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  // control
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_done,
  // user drain side
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available,
  // Avalon-MM read master
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);

  // One extra bit so buffered + in-flight (each up to FIFODEPTH) cannot overflow.
  localparam int                    SUMW     = FIFODEPTH_LOG2 + 2;
  localparam logic [ADDRESSWIDTH-1:0] WORD_STEP = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [FIFODEPTH_LOG2:0] PEND_ONE = 1;
  localparam logic [SUMW-1:0]         LIMIT    = SUMW'(FIFODEPTH);

  logic [ADDRESSWIDTH-1:0]   address_q, address_d;
  logic [ADDRESSWIDTH-1:0]   length_q,  length_d;
  logic [FIFODEPTH_LOG2:0]   pending_q, pending_d;
  logic [FIFODEPTH_LOG2:0]   fifo_used;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [SUMW-1:0]           in_use;
  logic                      accept;

  assign in_use = SUMW'(fifo_used) + SUMW'(pending_q);

  // fifo_full is implied by the in_use limit; it is kept as a direct guard.
  assign master_read       = (length_q != '0) && (in_use < LIMIT) && !fifo_full;
  assign master_address    = address_q;
  assign master_byteenable = '1;
  assign accept            = master_read & ~master_waitrequest;
  assign control_done      = (length_q == '0) && (pending_q == '0);

  // Next-state for the address/length window and the in-flight counter.
  // NOTE: combinational blocks use blocking '=' and assign defaults first so no latch is inferred; flops use '<=' only.
  always_comb begin
    address_d = address_q;
    length_d  = length_q;
    pending_d = pending_q;

    if (control_go && control_done) begin
      address_d = control_read_base;
      length_d  = control_read_length;
    end else if (accept) begin
      address_d = address_q + WORD_STEP;
      length_d  = length_q - WORD_STEP;
    end

    case ({accept, master_readdatavalid})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      length_q  <= '0;
      pending_q <= '0;
    end else begin
      address_q <= address_d;
      length_q  <= length_d;
      pending_q <= pending_d;
    end
  end

  mem_read_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2),
    .USE_MEMORY (FIFOUSEMEMORY)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .data  (master_readdata),
    .wrreq (master_readdatavalid),
    .rdreq (user_read_buffer),
    .q     (user_buffer_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .usedw (fifo_used)
  );

  assign user_data_available = ~fifo_empty;

endmodule : mem_read_buffer

// File: tb/tb_mem_read_buffer.sv
// Directed bench for mem_read_buffer: in-order slave with fixed read
// latency, queue-based model of the buffer, per-cycle output compare.
module tb_mem_read_buffer;

  localparam int DW    = 32;
  localparam int AW    = 30;
  localparam int BEW   = 4;
  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  control_read_base;
  logic [AW-1:0]  control_read_length;
  logic           control_go;
  logic           control_done;
  logic           user_read_buffer;
  logic [DW-1:0]  user_buffer_data;
  logic           user_data_available;
  logic [AW-1:0]  master_address;
  logic           master_read;
  logic [BEW-1:0] master_byteenable;
  logic [DW-1:0]  master_readdata;
  logic           master_readdatavalid;
  logic           master_waitrequest;

  mem_read_buffer #(
    .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .ADDRESSWIDTH(AW),
    .FIFODEPTH(DEPTH), .FIFODEPTH_LOG2(5), .FIFOUSEMEMORY(1)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .control_read_base    (control_read_base),
    .control_read_length  (control_read_length),
    .control_go           (control_go),
    .control_done         (control_done),
    .user_read_buffer     (user_read_buffer),
    .user_buffer_data     (user_buffer_data),
    .user_data_available  (user_data_available),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_byteenable    (master_byteenable),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave and model state ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          slave_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] pop_log[$];
  logic [DW-1:0] m_fifo[$];
  logic [AW-1:0] m_addr;
  int            m_words_left;
  int            m_outstanding;
  int            edge_no;

  // per-cycle knobs
  bit            pop_en;
  bit            pop_always;
  bit            go_pulse;
  logic [AW-1:0] go_base;
  logic [AW-1:0] go_len;
  int            stall_at;
  int            stall_left;

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    return {2'b11, a} ^ 32'h0055_AA00;
  endfunction

  function automatic bit m_done();
    return (m_words_left == 0) && (m_outstanding == 0);
  endfunction

  function automatic bit m_read();
    return (m_words_left != 0) && (m_fifo.size() + m_outstanding < DEPTH);
  endfunction

  task automatic model_reset();
    m_addr        = '0;
    m_words_left  = 0;
    m_outstanding = 0;
    m_fifo.delete();
    slave_q.delete();
  endtask

  task automatic compare();
    check("master_read",         master_read,         m_read());
    check("master_address",      master_address,      m_addr);
    check("control_done",        control_done,        m_done());
    check("user_data_available", user_data_available, m_fifo.size() != 0);
    check("user_buffer_data",    user_buffer_data,    (m_fifo.size() != 0) ? m_fifo[0] : '0);
    check("master_byteenable",   master_byteenable,   4'hF);
  endtask

  // One clock: compare at negedge, drive inputs, advance through posedge.
  task automatic step();
    bit            acc, rdv, pop, m_acc, m_go;
    logic [DW-1:0] rdata;
    logic [AW-1:0] acc_addr;
    compare();

    master_waitrequest = 1'b0;
    if (stall_at >= 0 && addr_log.size() == stall_at && stall_left > 0 && master_read) begin
      master_waitrequest = 1'b1;
      stall_left--;
    end
    acc      = master_read && !master_waitrequest;
    acc_addr = master_address;
    rdv      = (slave_q.size() != 0) && (slave_q[0].due == edge_no + 1);
    rdata    = rdv ? slave_q[0].data : 32'hDEAD_BEEF;
    master_readdatavalid = rdv;
    master_readdata      = rdata;

    pop = pop_always || (pop_en && user_data_available);
    user_read_buffer = pop;
    if (pop && user_data_available) pop_log.push_back(user_buffer_data);

    control_go          = go_pulse;
    control_read_base   = go_base;
    control_read_length = go_len;

    m_acc = m_read() && !master_waitrequest;
    m_go  = go_pulse && m_done();

    @(posedge clk);
    edge_no++;

    if (acc) begin
      addr_log.push_back(acc_addr);
      slave_q.push_back('{due: edge_no + LAT, data: data_for(acc_addr)});
    end
    if (rdv) void'(slave_q.pop_front());

    if (pop && m_fifo.size() != 0) void'(m_fifo.pop_front());
    if (rdv) m_fifo.push_back(rdata);
    if (m_go) begin
      m_addr       = go_base;
      m_words_left = int'(go_len) / BEW;
    end
    if (m_acc) begin
      m_addr = m_addr + AW'(BEW);
      m_words_left--;
      m_outstanding++;
    end
    if (rdv) m_outstanding--;

    go_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len);
    go_base  = base;
    go_len   = len;
    go_pulse = 1'b1;
    step();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (!(m_done() && m_fifo.size() == 0 && slave_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic check_addr_seq(input string name, input logic [AW-1:0] base, input int words);
    logic [AW-1:0] a;
    check({name, "_count"}, addr_log.size(), words);
    for (int i = 0; i < words && i < addr_log.size(); i++) begin
      a = base + AW'(i * BEW);
      check({name, "_addr"}, addr_log[i], a);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    pop_log.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    control_read_base = '0; control_read_length = '0; control_go = 1'b0;
    user_read_buffer = 1'b0; master_readdata = '0;
    master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    pop_en = 0; pop_always = 0; go_pulse = 0; go_base = '0; go_len = '0;
    stall_at = -1; stall_left = 0; edge_no = 0;
    model_reset();

    // Reset with clock running.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_master_read",  master_read, 1'b0);
    check("rst_done",         control_done, 1'b1);
    check("rst_available",    user_data_available, 1'b0);
    check("rst_byteenable",   master_byteenable, 4'hF);
    check("rst_address",      master_address, '0);
    check("rst_buffer_data",  user_buffer_data, '0);
    reset = 1'b0;
    step();

    // Pop on empty is ignored.
    pop_always = 1;
    repeat (3) step();
    pop_always = 0;

    // Basic 4-word transfer, user pops whenever data is available.
    clear_logs();
    pop_en = 1;
    start(30'h100, 30'd16);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("t1_done_before_last_return", control_done, 1'b0);
      if (k == 6) check("t1_done_after_last_return",  control_done, 1'b1);
    end
    run_until_idle("t1_idle", 50);
    check_addr_seq("t1", 30'h100, 4);
    check("t1_pop_count", pop_log.size(), 4);
    check("t1_pop0", pop_log.size() > 0 ? pop_log[0] : '0, 32'hC055_AB00);
    check("t1_pop3", pop_log.size() > 3 ? pop_log[3] : '0, 32'hC055_AB0C);

    // Throttle: 64 words, no pops until the FIFO fills.
    clear_logs();
    pop_en = 0;
    start(30'h1000, 30'd256);
    repeat (60) step();
    check("t2_reads_at_full",   addr_log.size(), 32);
    check("t2_read_low_full",   master_read, 1'b0);
    check("t2_available_full",  user_data_available, 1'b1);
    pop_always = 1;
    repeat (8) step();
    pop_always = 0;
    repeat (20) step();
    check("t2_reads_after_8pops", addr_log.size(), 40);
    pop_en = 1;
    run_until_idle("t2_idle", 500);
    check_addr_seq("t2", 30'h1000, 64);
    check("t2_pop_count", pop_log.size(), 64);
    for (int i = 0; i < 64 && i < pop_log.size(); i++)
      check("t2_pop_order", pop_log[i], data_for(30'h1000 + AW'(i * 4)));

    // Waitrequest for 3 cycles on the second read.
    clear_logs();
    stall_at = 1; stall_left = 3;
    start(30'h2000, 30'd32);
    run_until_idle("t3_idle", 100);
    stall_at = -1;
    check("t3_stall_used", stall_left, 0);
    check_addr_seq("t3", 30'h2000, 8);

    // Zero length go.
    clear_logs();
    start(30'h3000, 30'd0);
    repeat (5) step();
    check("t4_zero_reads", addr_log.size(), 0);
    check("t4_zero_done",  control_done, 1'b1);

    // Second go mid-transfer is ignored.
    clear_logs();
    start(30'h200, 30'd32);
    repeat (2) step();
    start(30'h900, 30'd64);
    run_until_idle("t4_idle", 100);
    check_addr_seq("t4_busy_go", 30'h200, 8);

    // Address wrap at the top of the address space.
    clear_logs();
    start(30'h3FFF_FFF8, 30'd16);
    run_until_idle("t5_idle", 50);
    check("t5_wrap_count", addr_log.size(), 4);
    check("t5_wrap_a1", addr_log.size() > 1 ? addr_log[1] : '0, 30'h3FFF_FFFC);
    check("t5_wrap_a2", addr_log.size() > 2 ? addr_log[2] : '1, 30'h0);
    check("t5_wrap_a3", addr_log.size() > 3 ? addr_log[3] : '0, 30'h4);

    // Reset after 3 of 8 reads.
    clear_logs();
    start(30'h4000, 30'd32);
    n = 0;
    while (addr_log.size() < 3 && n < 20) begin step(); n++; end
    check("t6_reads_before_reset", addr_log.size(), 3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_master_read", master_read, 1'b0);
    check("t6_rst_done",        control_done, 1'b1);
    check("t6_rst_available",   user_data_available, 1'b0);
    check("t6_rst_data",        user_buffer_data, '0);
    check("t6_rst_address",     master_address, '0);
    model_reset();
    master_readdatavalid = 1'b0;
    user_read_buffer     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    step();
    start(30'h5000, 30'd24);
    run_until_idle("t6_idle", 100);
    check_addr_seq("t6_after_reset", 30'h5000, 6);
    check("t6_pop_count", pop_log.size(), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_read_buffer
